// File: rtl/ps2_kb_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kb_scan_ctrl
// Brief    : Oversampling PS/2 keyboard receiver with E0/F0 prefix folding
//            and a valid/ready event FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kb_scan_ctrl #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       KB_Clk,
    input  logic       KB_Data,
    output logic [7:0] Key_Code,
    output logic       Key_Ext,
    output logic       Key_Release,
    output logic       Key_Valid,
    input  logic       Key_Ready,
    output logic       Frame_Err,
    output logic       Overflow
);

    localparam int C_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W  = C_ADDR_W + 1;
    localparam int C_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Synchronisers reset high so a reset never manufactures a falling edge
    logic r_kbc_s1, r_kbc_s2, r_kbc_d;
    logic r_kbd_s1, r_kbd_s2;
    logic w_fall;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_kbc_s1 <= 1'b1;
            r_kbc_s2 <= 1'b1;
            r_kbc_d  <= 1'b1;
            r_kbd_s1 <= 1'b1;
            r_kbd_s2 <= 1'b1;
        end else begin
            r_kbc_s1 <= KB_Clk;
            r_kbc_s2 <= r_kbc_s1;
            r_kbc_d  <= r_kbc_s2;
            r_kbd_s1 <= KB_Data;
            r_kbd_s2 <= r_kbd_s1;
        end
    end

    assign w_fall = r_kbc_d & ~r_kbc_s2;

    // Frame FSM
    state_t            r_state, w_state_nxt;
    logic [2:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              r_parity, w_parity_nxt;
    logic [C_TO_W-1:0] r_to_cnt;
    logic              w_timeout;
    logic              w_byte_done;
    logic              w_frame_err;

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        w_byte_done   = 1'b0;
        w_frame_err   = 1'b0;
        w_timeout     = (r_state != S_IDLE) && !w_fall &&
                        (r_to_cnt == C_TO_W'(TIMEOUT_CYCLES - 1));
        if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_kbd_s2) begin
                        w_state_nxt   = S_DATA;
                        w_bit_cnt_nxt = 3'd0;
                    end
                end
                S_DATA: begin
                    w_shift_nxt[r_bit_cnt] = r_kbd_s2;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
                S_PARITY: begin
                    w_parity_nxt = r_kbd_s2;
                    w_state_nxt  = S_STOP;
                end
                default: begin
                    if (r_kbd_s2 && (^{r_shift, r_parity})) begin
                        w_byte_done = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_frame_err = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_parity_nxt;
            if (r_state == S_IDLE || w_fall) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + C_TO_W'(1);
            end
        end
    end

    // Prefix decoder; queue entry layout is {ext, release, code}
    logic       r_ext_flag, r_rel_flag;
    logic       r_push;
    logic [9:0] r_push_data;
    logic       r_frame_err;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ext_flag  <= 1'b0;
            r_rel_flag  <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= 10'h000;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= w_frame_err;
            if (w_frame_err) begin
                r_ext_flag <= 1'b0;
                r_rel_flag <= 1'b0;
            end else if (w_byte_done) begin
                if (r_shift == 8'hE0) begin
                    r_ext_flag <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_rel_flag <= 1'b1;
                end else begin
                    r_push      <= 1'b1;
                    r_push_data <= {r_ext_flag, r_rel_flag, r_shift};
                    r_ext_flag  <= 1'b0;
                    r_rel_flag  <= 1'b0;
                end
            end
        end
    end

    // Event FIFO
    logic [9:0]          r_mem [FIFO_DEPTH];
    logic [C_ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [C_CNT_W-1:0]  r_count;
    logic [9:0]          r_last;
    logic                r_overflow;
    logic                w_full, w_pop, w_wr;
    logic [9:0]          w_head;

    assign w_full = (r_count == C_CNT_W'(FIFO_DEPTH));
    assign w_pop  = (r_count != '0) & Key_Ready;
    assign w_wr   = r_push & (!w_full | w_pop);

    always_ff @(posedge Clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last     <= 10'h000;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_push & w_full & ~w_pop;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + C_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_ADDR_W'(1);
            end
            if (r_count != '0) begin
                r_last <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // When empty, the outputs keep showing the most recently presented entry
    always_comb begin
        w_head = (r_count != '0) ? r_mem[r_rd_ptr] : r_last;
    end

    assign Key_Code    = w_head[7:0];
    assign Key_Release = w_head[8];
    assign Key_Ext     = w_head[9];
    assign Key_Valid   = (r_count != '0);
    assign Frame_Err   = r_frame_err;
    assign Overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kb_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kb_scan_ctrl
// Brief    : Directed self-checking bench for ps2_kb_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kb_scan_ctrl;

    localparam int TO_CYC = 200;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       KB_Clk = 1'b1;
    logic       KB_Data = 1'b1;
    logic       Key_Ready = 1'b1;
    logic [7:0] Key_Code;
    logic       Key_Ext, Key_Release, Key_Valid, Frame_Err, Overflow;

    int vectors = 0;
    int miscompares = 0;
    int ovf_cnt = 0;

    ps2_kb_scan_ctrl #(
        .TIMEOUT_CYCLES (TO_CYC),
        .FIFO_DEPTH     (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .KB_Clk      (KB_Clk),
        .KB_Data     (KB_Data),
        .Key_Code    (Key_Code),
        .Key_Ext     (Key_Ext),
        .Key_Release (Key_Release),
        .Key_Valid   (Key_Valid),
        .Key_Ready   (Key_Ready),
        .Frame_Err   (Frame_Err),
        .Overflow    (Overflow)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (Overflow) ovf_cnt <= ovf_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_fall(input logic b);
        KB_Data = b;
        repeat (8) @(posedge Clk);
        #1 KB_Clk = 1'b0;
    endtask

    task automatic ps2_rise();
        repeat (8) @(posedge Clk);
        #1 KB_Clk = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par);
        logic par;
        par = (~^d) ^ bad_par;
        return {1'b1, par, d, 1'b0};
    endfunction

    // Sends the first n bits of a frame; the last bit's clock is left low
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_fall(f[i]);
            if (i < n - 1) ps2_rise();
        end
    endtask

    task automatic send_key(input logic [7:0] d);
        send_bits(mk_frame(d, 1'b0), 11);
        ps2_rise();
    endtask

    // Called right after the stop-bit fall; event visible exactly on the 4th edge
    task automatic expect_event(input string tag, input logic [7:0] code,
                                input logic ext, input logic rel);
        repeat (3) @(posedge Clk);
        #1 check({tag, "_early"}, Key_Valid, 0);
        @(posedge Clk);
        #1 check({tag, "_valid"}, Key_Valid, 1);
        check({tag, "_code"}, Key_Code, code);
        check({tag, "_ext"}, Key_Ext, ext);
        check({tag, "_rel"}, Key_Release, rel);
        @(posedge Clk);
        #1 check({tag, "_popped"}, Key_Valid, 0);
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        check("rst_valid", Key_Valid, 0);
        check("rst_code", Key_Code, 8'h00);
        check("rst_ext", Key_Ext, 0);
        check("rst_rel", Key_Release, 0);
        check("rst_ferr", Frame_Err, 0);
        check("rst_ovf", Overflow, 0);

        // Plain make code
        send_bits(mk_frame(8'h1C, 1'b0), 11);
        expect_event("make1c", 8'h1C, 1'b0, 1'b0);
        ps2_rise();

        // Release of 1C
        send_key(8'hF0);
        check("f0_noevent", Key_Valid, 0);
        send_bits(mk_frame(8'h1C, 1'b0), 11);
        expect_event("brk1c", 8'h1C, 1'b0, 1'b1);
        ps2_rise();

        // Extended release of 75
        send_key(8'hE0);
        check("e0_noevent", Key_Valid, 0);
        send_key(8'hF0);
        check("e0f0_noevent", Key_Valid, 0);
        send_bits(mk_frame(8'h75, 1'b0), 11);
        expect_event("ebrk75", 8'h75, 1'b1, 1'b1);
        ps2_rise();

        // Parity error after F0 clears the release flag
        send_key(8'hF0);
        send_bits(mk_frame(8'h1C, 1'b1), 11);
        repeat (3) @(posedge Clk);
        #1 check("par_ferr", Frame_Err, 1);
        @(posedge Clk);
        #1 check("par_ferr_pulse", Frame_Err, 0);
        repeat (3) @(posedge Clk);
        #1 check("par_noevent", Key_Valid, 0);
        ps2_rise();
        send_bits(mk_frame(8'h1C, 1'b0), 11);
        expect_event("after_par", 8'h1C, 1'b0, 1'b0);
        ps2_rise();

        // Timeout after start + 4 data bits
        send_bits(mk_frame(8'h32, 1'b0), 5);
        ps2_rise();
        seen = 0;
        for (int i = 0; i < TO_CYC + 100; i++) begin
            @(posedge Clk);
            #1 if (Frame_Err) begin
                seen = 1;
                break;
            end
        end
        check("timeout_ferr", seen, 1);
        check("timeout_noevent", Key_Valid, 0);
        send_bits(mk_frame(8'h32, 1'b0), 11);
        expect_event("after_to", 8'h32, 1'b0, 1'b0);
        ps2_rise();

        // Overflow on fifth push with consumer stalled
        Key_Ready = 1'b0;
        send_key(8'h1C);
        send_key(8'h32);
        send_key(8'h21);
        send_key(8'h23);
        check("full_ovf_none", ovf_cnt, 0);
        check("full_valid", Key_Valid, 1);
        check("full_head", Key_Code, 8'h1C);
        send_key(8'h2B);
        check("ovf_once", ovf_cnt, 1);
        check("ovf_head_kept", Key_Code, 8'h1C);
        Key_Ready = 1'b1;
        check("pop0", Key_Code, 8'h1C);
        @(posedge Clk);
        #1 check("pop1", Key_Code, 8'h32);
        @(posedge Clk);
        #1 check("pop2", Key_Code, 8'h21);
        @(posedge Clk);
        #1 check("pop3", Key_Code, 8'h23);
        check("pop3_valid", Key_Valid, 1);
        @(posedge Clk);
        #1 check("drained", Key_Valid, 0);
        check("hold_last", Key_Code, 8'h23);
        check("ovf_total", ovf_cnt, 1);

        // Reset mid-frame with two events queued
        Key_Ready = 1'b0;
        send_key(8'h1C);
        send_key(8'h32);
        check("pre_rst_valid", Key_Valid, 1);
        send_bits(mk_frame(8'h1C, 1'b0), 6);
        ps2_rise();
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        check("midrst_valid", Key_Valid, 0);
        check("midrst_code", Key_Code, 8'h00);
        Key_Ready = 1'b1;
        send_bits(mk_frame(8'h1C, 1'b0), 11);
        expect_event("post_rst", 8'h1C, 1'b0, 1'b0);
        ps2_rise();
        repeat (20) @(posedge Clk);
        #1 check("post_rst_single", Key_Valid, 0);
        check("post_rst_noerr", Frame_Err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
